// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, frame sync byte,
// requester IDs.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    STROBE,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;

  localparam logic REQ_NONCE  = 1'b0;
  localparam logic REQ_STATUS = 1'b1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Two-input round-robin arbiter. The pointer names the requester that wins a tie and
// moves to the other requester whenever a grant is accepted.
module uart_rr_arbiter
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_id
);

  logic ptr;

  always_comb begin
    grant_valid = |req;
    grant_id    = req[ptr] ? ptr : ~ptr;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= REQ_NONCE;
    end else if (accept && grant_valid) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Sequences nonce (MSB byte first) and status messages onto a single-byte UART.
// Define UART_TX_FRAME_EN to wrap every message as sync byte, payload, then XOR checksum.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NONCE_BYTES   = 4,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     nonce_valid,
  input  logic [8*NONCE_BYTES-1:0] nonce,
  output logic                     nonce_ready,
  input  logic                     status_valid,
  input  logic [7:0]               status,
  output logic                     status_ready,
  input  logic                     is_transmitting,
  input  logic                     is_receiving,
  output logic                     txce,
  output logic [7:0]               tx,
  output logic                     busy
);

`ifdef UART_TX_FRAME_EN
  localparam int FRAME_EXTRA = 2;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  localparam int BUF_W    = 8 * (NONCE_BYTES + FRAME_EXTRA);
  localparam int MSG_MAX  = NONCE_BYTES + FRAME_EXTRA;
  localparam int CW       = $clog2(MSG_MAX + 1);
  localparam int TW       = $clog2(START_TIMEOUT + 1);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] NONCE_COUNT  = CW'(NONCE_BYTES + FRAME_EXTRA);
  localparam logic [CW-1:0] STATUS_COUNT = CW'(1 + FRAME_EXTRA);
  localparam logic [TW-1:0] TMO_LAST     = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST_C   = GW'(GAP_LAST);

  state_t          state;
  logic [BUF_W-1:0] shift_reg;
  logic [CW-1:0]   byte_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      tx_last;

  logic [BUF_W-1:0] nonce_load;
  logic [BUF_W-1:0] status_load;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             gap_done;
  logic [7:0]       head_byte;

`ifdef UART_TX_FRAME_EN
  logic [7:0] xor_chain [NONCE_BYTES+1];
  genvar gi;

  assign xor_chain[0] = 8'h00;
  for (gi = 0; gi < NONCE_BYTES; gi++) begin : g_xor
    assign xor_chain[gi+1] = xor_chain[gi] ^ nonce[8*gi +: 8];
  end

  // A one-byte payload is its own checksum, so status frames are sync, byte, byte.
  assign nonce_load  = {FRAME_SYNC, nonce, xor_chain[NONCE_BYTES]};
  assign status_load = BUF_W'({FRAME_SYNC, status, status}) << (BUF_W - 24);
`else
  assign nonce_load  = nonce;
  assign status_load = BUF_W'(status) << (BUF_W - 8);
`endif

  uart_rr_arbiter u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         ({status_valid, nonce_valid}),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign accept       = (state == ARB);
  assign nonce_ready  = accept && grant_valid && (grant_id == REQ_NONCE);
  assign status_ready = accept && grant_valid && (grant_id == REQ_STATUS);
  assign busy         = (state != IDLE);

  // The strobe must drop in the very cycle the UART starts receiving, so it is
  // gated directly rather than registered.
  assign head_byte = shift_reg[BUF_W-1 -: 8];
  assign txce      = (state == STROBE) && !is_receiving;
  assign tx        = txce ? head_byte : tx_last;
  assign gap_done  = (gap_cnt >= GAP_LAST_C);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      tx_last   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (nonce_valid || status_valid) state <= ARB;
        end
        ARB: begin
          if (grant_valid) begin
            shift_reg <= (grant_id == REQ_STATUS) ? status_load : nonce_load;
            byte_cnt  <= (grant_id == REQ_STATUS) ? STATUS_COUNT : NONCE_COUNT;
            state     <= STROBE;
          end else begin
            state <= IDLE;
          end
        end
        STROBE: begin
          if (!is_receiving) begin
            tx_last   <= head_byte;
            shift_reg <= shift_reg << 8;
            byte_cnt  <= (byte_cnt != '0) ? byte_cnt - 1'b1 : byte_cnt;
            // The strobe cycle itself is the first cycle of the start timeout.
            tmo_cnt   <= TW'(1);
            state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (is_transmitting || tmo_cnt >= TMO_LAST) begin
            state <= WAIT_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!is_transmitting) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_done) begin
            state <= (byte_cnt != '0) ? STROBE : IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small UART busy-flag model; expected
// byte streams include framing when UART_TX_FRAME_EN is defined.
module tb_uart_tx_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        nonce_valid = 1'b0;
  logic [31:0] nonce = 32'h0;
  logic        status_valid = 1'b0;
  logic [7:0]  status = 8'h00;
  logic        is_transmitting = 1'b0;
  logic        is_receiving = 1'b0;
  logic        nonce_ready;
  logic        status_ready;
  logic        txce;
  logic [7:0]  tx;
  logic        busy;

  uart_tx_scheduler #(
    .NONCE_BYTES   (4),
    .START_TIMEOUT (16),
    .GAP_CYCLES    (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .nonce_valid     (nonce_valid),
    .nonce           (nonce),
    .nonce_ready     (nonce_ready),
    .status_valid    (status_valid),
    .status          (status),
    .status_ready    (status_ready),
    .is_transmitting (is_transmitting),
    .is_receiving    (is_receiving),
    .txce            (txce),
    .tx              (tx),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // UART model: busy flag rises the cycle after txce and stays up for 10 cycles.
  logic model_en = 1'b1;
  logic model_fire = 1'b0;
  int   tx_left = 0;
  always @(posedge clock) begin
    model_fire = model_en && txce;
    #1;
    if (model_fire) begin
      is_transmitting = 1'b1;
      tx_left = 10;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) is_transmitting = 1'b0;
    end
  end

  // Monitor: every strobe, every ready pulse.
  logic [7:0] log_q[$];
  int         ts_q[$];
  logic       grant_q[$];
  int         nr_cnt = 0;
  int         sr_cnt = 0;
  int         dbl_cnt = 0;
  logic       prev_txce = 1'b0;
  always @(negedge clock) begin
    if (txce) begin
      log_q.push_back(tx);
      ts_q.push_back(cyc);
      if (prev_txce) dbl_cnt++;
    end
    prev_txce = txce;
    if (nonce_ready) begin
      nr_cnt++;
      grant_q.push_back(1'b0);
    end
    if (status_ready) begin
      sr_cnt++;
      grant_q.push_back(1'b1);
    end
  end

  int         checks = 0;
  int         failures = 0;
  int         nr_seen = 0;
  int         sr_seen = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic gq(input int i);
    return (i < grant_q.size()) ? grant_q[i] : 1'bx;
  endfunction

  function automatic int ts_at(input int i);
    return (i < ts_q.size()) ? ts_q[i] : -1000;
  endfunction

  // One clock; drop each request once its ready pulse has been seen.
  task automatic step();
    @(posedge clock);
    #1;
    if (nr_cnt != nr_seen) begin
      nonce_valid = 1'b0;
      nr_seen = nr_cnt;
    end
    if (sr_cnt != sr_seen) begin
      status_valid = 1'b0;
      sr_seen = sr_cnt;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(nonce_valid == 1'b0 && status_valid == 1'b0 && busy == 1'b0) && n < 600);
    check({tag, "_finished"}, 32'(n < 600), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    nonce_valid = 1'b0;
    status_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    nr_seen = nr_cnt;
    sr_seen = sr_cnt;
  endtask

  task automatic add_msg(input logic [31:0] val, input int n);
`ifdef UART_TX_FRAME_EN
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
`endif
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back(val[8*i +: 8]);
`ifdef UART_TX_FRAME_EN
      x ^= val[8*i +: 8];
`endif
    end
`ifdef UART_TX_FRAME_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic check_bytes(input string tag, input int base);
    check({tag, "_count"}, 32'(log_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(log_q[base+i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nb, sb, gb, n;
    logic [7:0] last_exp;

    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_txce", 32'(txce), 32'd0);
    check("rst_tx", 32'(tx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_nonce_ready", 32'(nonce_ready), 32'd0);
    check("rst_status_ready", 32'(status_ready), 32'd0);

    // Plain nonce message with a responsive UART
    @(posedge clock); #1;
    base = log_q.size(); nb = nr_cnt; sb = sr_cnt;
    nonce = 32'h12345678;
    nonce_valid = 1'b1;
    wait_idle("nonce");
    add_msg(32'h12345678, 4);
    last_exp = exp_q[exp_q.size()-1];
    check_bytes("nonce", base);
    check("nonce_ready_pulses", 32'(nr_cnt - nb), 32'd1);
    check("nonce_no_status_ready", 32'(sr_cnt - sb), 32'd0);
    check("nonce_byte_spacing", 32'(ts_at(base+1) - ts_at(base)), 32'd14);
    check("nonce_busy_after", 32'(busy), 32'd0);
    check("nonce_tx_holds", 32'(tx), 32'(last_exp));

    // Simultaneous requests straight after reset: nonce wins the tie
    do_reset();
    base = log_q.size(); gb = grant_q.size();
    nonce = 32'hCAFEF00D; status = 8'h5A;
    nonce_valid = 1'b1; status_valid = 1'b1;
    wait_idle("pair1");
    check("pair1_first_grant", 32'(gq(gb)), 32'd0);
    check("pair1_second_grant", 32'(gq(gb+1)), 32'd1);
    add_msg(32'hCAFEF00D, 4);
    add_msg(32'h0000005A, 1);
    check_bytes("pair1", base);

    // Lone nonce, so the last grant is nonce and the next tie goes to status
    base = log_q.size();
    nonce = 32'h01020304;
    nonce_valid = 1'b1;
    wait_idle("lone");
    add_msg(32'h01020304, 4);
    check_bytes("lone", base);

    base = log_q.size(); gb = grant_q.size();
    nonce = 32'h55AA55AA; status = 8'hC3;
    nonce_valid = 1'b1; status_valid = 1'b1;
    wait_idle("pair2");
    check("pair2_first_grant", 32'(gq(gb)), 32'd1);
    check("pair2_second_grant", 32'(gq(gb+1)), 32'd0);
    add_msg(32'h000000C3, 1);
    add_msg(32'h55AA55AA, 4);
    check_bytes("pair2", base);

    // Half-duplex hold-off
    base = log_q.size();
    is_receiving = 1'b1;
    status = 8'h3C;
    status_valid = 1'b1;
    repeat (40) step();
    check("holdoff_no_txce", 32'(log_q.size() - base), 32'd0);
    check("holdoff_busy", 32'(busy), 32'd1);
    is_receiving = 1'b0;
    wait_idle("holdoff");
    add_msg(32'h0000003C, 1);
    check_bytes("holdoff", base);

    // UART never raises its busy flag: bytes advance on the start timeout
    model_en = 1'b0;
    base = log_q.size();
    nonce = 32'hA1B2C3D4;
    nonce_valid = 1'b1;
    wait_idle("timeout");
    add_msg(32'hA1B2C3D4, 4);
    n = exp_q.size();
    check_bytes("timeout", base);
    for (int i = 1; i < n; i++)
      check($sformatf("timeout_spacing%0d", i), 32'(ts_at(base+i) - ts_at(base+i-1)), 32'd19);
    model_en = 1'b1;
    repeat (15) step();

    // Reset in the middle of a message
    base = log_q.size();
    nonce = 32'h0BADF00D;
    nonce_valid = 1'b1;
    n = 0;
    while (log_q.size() - base < 2 && n < 300) begin
      step();
      n++;
    end
    check("midrst_reached_byte2", 32'(n < 300), 32'd1);
    repeat (3) step();
    reset = 1'b0;
    nonce_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midrst_txce", 32'(txce), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx", 32'(tx), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    nr_seen = nr_cnt; sr_seen = sr_cnt;
    base = log_q.size();
    repeat (60) step();
    check("midrst_no_more_bytes", 32'(log_q.size() - base), 32'd0);
    nonce = 32'h11223344;
    nonce_valid = 1'b1;
    wait_idle("after_rst");
    add_msg(32'h11223344, 4);
    check_bytes("after_rst", base);

    check("no_back_to_back_txce", 32'(dbl_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
